// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: FSM state codes, line levels and a
// counter-width helper used by the transmitter (and later the receiver).
package serial_link_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP
    } tx_state_e;

    // Counter width for a 0..n-1 count; a 1-bit counter is kept even when n <= 2.
    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_tx_frame_if.sv
// Producer-side word handshake plus the serial line outputs of serial_tx_frame.
// Handshake: a word transfers on the rising edge where tx_valid && tx_ready;
// tx_data is sampled only on that edge, and tx_valid while tx_ready is low is ignored.
interface serial_tx_frame_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_out;
    logic              busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_out,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_out,
        output busy
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 while enabled and flags the last count
// as the bit-advance tick; held at 0 while disabled.
module baud_tick_gen
    import serial_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int                CNT_W   = min1_clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = en && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!en || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/serial_tx_frame.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB first,
// stop bit, each held CLKS_PER_BIT clocks on a registered line output.
module serial_tx_frame
    import serial_link_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_tx_frame_if.slave    tx_if,
    output logic [1:0]          o_dbg_state
);
    localparam int               BIT_W    = min1_clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    tx_state_e         r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_tx_out;
    logic              r_tx_ready;
    logic              w_tick;
    logic              w_baud_en;

    // The divider runs from the accept edge onward, so the start bit spans exactly C clocks.
    assign w_baud_en = (r_state != S_IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (w_baud_en),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_tx_out   <= LINE_IDLE;
            r_tx_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tx_if.tx_valid && r_tx_ready) begin
                        r_state    <= S_START;
                        r_shift    <= tx_if.tx_data;
                        r_tx_out   <= START_BIT;
                        r_tx_ready <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_state  <= S_DATA;
                        r_tx_out <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state   <= S_STOP;
                            r_bit_cnt <= '0;
                            r_tx_out  <= STOP_BIT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx_out  <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_state    <= S_IDLE;
                        r_tx_out   <= LINE_IDLE;
                        r_tx_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_if.tx_out   = r_tx_out;
    assign tx_if.tx_ready = r_tx_ready;
    assign tx_if.busy     = ~r_tx_ready;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: one instance at DATA_W=8/C=4, one at DATA_W=4/C=1,
// line samples compared against a bit-list model of each frame.
module tb_serial_tx_frame;
    import serial_link_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_tx_frame_if #(.DATA_W(8)) a_if ();
    serial_tx_frame_if #(.DATA_W(4)) b_if ();
    logic [1:0] a_state;
    logic [1:0] b_state;

    serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .tx_if       (a_if),
        .o_dbg_state (a_state)
    );

    serial_tx_frame #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .tx_if       (b_if),
        .o_dbg_state (b_state)
    );

    // ---------------- scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for every clock of one frame: start, data LSB first, stop.
    function automatic void build_frame(input logic [31:0] d, input int w, input int c);
        logic [0:0] bv;
        exp_q.delete();
        for (int b = 0; b < w + 2; b++) begin
            if (b == 0)      bv = START_BIT;
            else if (b <= w) bv = d[b-1];
            else             bv = STOP_BIT;
            for (int r = 0; r < c; r++) exp_q.push_back(bv);
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic frame_a(input logic [7:0] d, input bit chained, input bit keep_valid,
                           input bit disturb);
        int low = 0;
        int k = 0;
        build_frame(32'(d), 8, 4);
        if (!chained) @(negedge clk);
        a_if.tx_data  = d;
        a_if.tx_valid = 1'b1;
        check("a_ready_pre", 32'(a_if.tx_ready), 1);
        @(posedge clk);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (!keep_valid) a_if.tx_valid = 1'b0;
            a_if.tx_data = 8'($urandom);
            if (disturb && k == 12) a_if.tx_valid = 1'b1;
            check("a_line", 32'(a_if.tx_out), 32'(exp_q.pop_front()));
            check("a_busy", 32'(a_if.busy), 1);
            if (a_if.tx_ready == 1'b0) low++;
            k++;
        end
        @(negedge clk);
        if (!keep_valid) a_if.tx_valid = 1'b0;
        check("a_ready_low_clks", 32'(low), 40);
        check("a_idle_line", 32'(a_if.tx_out), 1);
        check("a_ready_post", 32'(a_if.tx_ready), 1);
        check("a_busy_post", 32'(a_if.busy), 0);
    endtask

    task automatic frame_b(input logic [3:0] d, input bit chained, input bit keep_valid);
        int low = 0;
        build_frame(32'(d), 4, 1);
        if (!chained) @(negedge clk);
        b_if.tx_data  = d;
        b_if.tx_valid = 1'b1;
        check("b_ready_pre", 32'(b_if.tx_ready), 1);
        @(posedge clk);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (!keep_valid) b_if.tx_valid = 1'b0;
            b_if.tx_data = 4'($urandom);
            check("b_line", 32'(b_if.tx_out), 32'(exp_q.pop_front()));
            if (b_if.tx_ready == 1'b0) low++;
        end
        @(negedge clk);
        if (!keep_valid) b_if.tx_valid = 1'b0;
        check("b_ready_low_clks", 32'(low), 6);
        check("b_idle_line", 32'(b_if.tx_out), 1);
        check("b_ready_post", 32'(b_if.tx_ready), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int  bad;
        bit  kv;
        bit  prev_kv;
        a_if.tx_valid = 1'b0;
        a_if.tx_data  = '0;
        b_if.tx_valid = 1'b0;
        b_if.tx_data  = '0;

        // Asynchronous reset with no clock edge in between.
        #2 rst = 1'b1;
        #1;
        check("rst_a_line", 32'(a_if.tx_out), 1);
        check("rst_a_ready", 32'(a_if.tx_ready), 1);
        check("rst_a_busy", 32'(a_if.busy), 0);
        check("rst_a_state", 32'(a_state), 32'(ST_IDLE));
        check("rst_b_line", 32'(b_if.tx_out), 1);
        check("rst_b_ready", 32'(b_if.tx_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Single frame of 8'hA5.
        frame_a(8'hA5, 1'b0, 1'b0, 1'b0);

        // Back-to-back with tx_valid held high.
        frame_a(8'h00, 1'b0, 1'b1, 1'b0);
        frame_a(8'hFF, 1'b1, 1'b0, 1'b0);

        // Data hold-off: tx_data churns and tx_valid pulses mid-frame.
        frame_a(8'h3C, 1'b0, 1'b0, 1'b1);
        bad = 0;
        repeat (45) begin
            @(negedge clk);
            if (a_if.tx_out !== 1'b1 || a_if.tx_ready !== 1'b1) bad++;
        end
        check("a_holdoff_no_accept", 32'(bad), 0);

        // Reset during bit 3 of 8'h00.
        @(negedge clk);
        a_if.tx_data  = 8'h00;
        a_if.tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_if.tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("abort_pre_line", 32'(a_if.tx_out), 0);
        check("abort_pre_busy", 32'(a_if.busy), 1);
        #2 rst = 1'b1;
        #1;
        check("abort_line", 32'(a_if.tx_out), 1);
        check("abort_ready", 32'(a_if.tx_ready), 1);
        check("abort_busy", 32'(a_if.busy), 0);
        check("abort_state", 32'(a_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (a_if.tx_out !== 1'b1 || a_if.tx_ready !== 1'b1 || a_state !== ST_IDLE) bad++;
        end
        check("abort_no_stale", 32'(bad), 0);

        // Randomized frames on the C=4 instance, sometimes back-to-back.
        prev_kv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            kv = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!prev_kv) repeat ($urandom_range(0, 3)) @(negedge clk);
            frame_a(8'($urandom), prev_kv, kv, 1'b0);
            prev_kv = kv;
        end

        // C=1, DATA_W=4 instance.
        frame_b(4'b1001, 1'b0, 1'b0);
        prev_kv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            kv = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!prev_kv) repeat ($urandom_range(0, 2)) @(negedge clk);
            frame_b(4'($urandom), prev_kv, kv);
            prev_kv = kv;
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
